ser2par_frame: RTL and testbench

Parametrised serial-to-parallel deserialiser; successor to the fixed 8-bit shift-right converter. Adds configurable word width and bit order, a bit counter with a word-complete strobe, a valid/ready output handshake through a holding register, frame resync, and sticky overrun detection. Sits between a bit-serial receiver front end (SPI/UART-style bit sampler) and word-oriented consumers.

---
 rtl/ser2par_frame.sv | 89 ++++++++
 tb/tb_ser2par_frame.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_frame.sv
// Serial-to-parallel deserialiser with configurable width and bit order.
// Provides a word-complete holding register with valid/ready handshake, frame resync and sticky overrun.
module ser2par_frame #(
   parameter int unsigned BitLen   = 8,
   parameter bit          LsbFirst = 1'b1,
   localparam int unsigned CntW    = $clog2(BitLen + 1)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              SerDataIn,
   input  logic              SerDataEn,
   input  logic              SerFrameStart,
   input  logic              ParDataRdy,
   input  logic              OverrunClr,
   output logic [BitLen-1:0] ParDataOut,
   output logic              ParDataVal,
   output logic [CntW-1:0]   BitCnt,
   output logic              Overrun
);

   logic [BitLen-1:0] r_shreg;
   logic [CntW-1:0]   r_cnt;
   logic [BitLen-1:0] r_out;
   logic              r_val;
   logic              r_ovr;

   logic [BitLen-1:0] w_shift_base;
   logic [BitLen-1:0] w_shreg_nxt;
   logic              w_last;
   logic              w_load;
   logic              w_drop;

   // A resync bit starts a new word, so it shifts into a cleared register
   assign w_shift_base = SerFrameStart ? '0 : r_shreg;

   generate
      if (LsbFirst) begin : g_lsb
         assign w_shreg_nxt = {SerDataIn, w_shift_base[BitLen-1:1]};
      end else begin : g_msb
         assign w_shreg_nxt = {w_shift_base[BitLen-2:0], SerDataIn};
      end
   endgenerate

   assign w_last = SerDataEn && !SerFrameStart && (r_cnt == CntW'(BitLen - 1));
   assign w_load = w_last && (!r_val || ParDataRdy);
   assign w_drop = w_last && r_val && !ParDataRdy;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_shreg <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_val   <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         if (SerDataEn) begin
            r_shreg <= w_shreg_nxt;
            if (SerFrameStart)
               r_cnt <= CntW'(1);
            else if (w_last)
               r_cnt <= '0;
            else
               r_cnt <= r_cnt + CntW'(1);
         end else if (SerFrameStart) begin
            r_shreg <= '0;
            r_cnt   <= '0;
         end

         // A load on the same edge as an accept keeps the valid flag up
         if (w_load) begin
            r_out <= w_shreg_nxt;
            r_val <= 1'b1;
         end else if (r_val && ParDataRdy) begin
            r_val <= 1'b0;
         end

         if (w_drop)
            r_ovr <= 1'b1;
         else if (OverrunClr)
            r_ovr <= 1'b0;
      end
   end

   assign ParDataOut = r_out;
   assign ParDataVal = r_val;
   assign BitCnt     = r_cnt;
   assign Overrun    = r_ovr;

endmodule

// File: tb/tb_ser2par_frame.sv
// Scoreboard bench for ser2par_frame: one LSB-first and one MSB-first instance fed the same stream.
module tb_ser2par_frame;
   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          Clk = 1'b0;
   logic          Rst;
   logic          SerDataIn, SerDataEn, SerFrameStart, ParDataRdy, OverrunClr;
   logic [W-1:0]  out_l, out_m;
   logic          val_l, val_m, ovr_l, ovr_m;
   logic [CW-1:0] cnt_l, cnt_m;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] q_l[$];
   logic [W-1:0] q_m[$];

   ser2par_frame #(.BitLen(W), .LsbFirst(1'b1)) u_lsb (
      .Clk(Clk), .Rst(Rst), .SerDataIn(SerDataIn), .SerDataEn(SerDataEn),
      .SerFrameStart(SerFrameStart), .ParDataRdy(ParDataRdy), .OverrunClr(OverrunClr),
      .ParDataOut(out_l), .ParDataVal(val_l), .BitCnt(cnt_l), .Overrun(ovr_l));

   ser2par_frame #(.BitLen(W), .LsbFirst(1'b0)) u_msb (
      .Clk(Clk), .Rst(Rst), .SerDataIn(SerDataIn), .SerDataEn(SerDataEn),
      .SerFrameStart(SerFrameStart), .ParDataRdy(ParDataRdy), .OverrunClr(OverrunClr),
      .ParDataOut(out_m), .ParDataVal(val_m), .BitCnt(cnt_m), .Overrun(ovr_m));

   always #5 Clk = ~Clk;

   // Scoreboard: every word that crosses the valid/ready handshake is popped and compared
   always @(negedge Clk) begin
      if (!Rst && val_l && ParDataRdy) begin
         checks++;
         if (q_l.size() == 0) begin
            errors++;
            $display("FAIL sb_lsb unexpected word %h", out_l);
         end else begin
            logic [W-1:0] e;
            e = q_l.pop_front();
            if (out_l !== e) begin
               errors++;
               $display("FAIL sb_lsb got %h exp %h", out_l, e);
            end
         end
      end
      if (!Rst && val_m && ParDataRdy) begin
         checks++;
         if (q_m.size() == 0) begin
            errors++;
            $display("FAIL sb_msb unexpected word %h", out_m);
         end else begin
            logic [W-1:0] e;
            e = q_m.pop_front();
            if (out_m !== e) begin
               errors++;
               $display("FAIL sb_msb got %h exp %h", out_m, e);
            end
         end
      end
   end

   function automatic logic [W-1:0] rev(input logic [W-1:0] v);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = v[W-1-i];
      return r;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input logic fs);
      SerDataIn     = b;
      SerDataEn     = 1'b1;
      SerFrameStart = fs;
      tick();
      SerDataIn     = 1'b0;
      SerDataEn     = 1'b0;
      SerFrameStart = 1'b0;
   endtask

   // Bits go out v[0] first; the MSB-first instance therefore sees the reversed word
   task automatic send_word(input logic [W-1:0] v, input bit expect_load);
      if (expect_load) begin
         q_l.push_back(v);
         q_m.push_back(rev(v));
      end
      for (int i = 0; i < W; i++) drive_bit(v[i], 1'b0);
   endtask

   task automatic test_reset();
      checks++;
      if ({out_l, val_l, cnt_l, ovr_l} !== '0) begin
         errors++;
         $display("FAIL reset_lsb got out=%h val=%b cnt=%0d ovr=%b exp all 0", out_l, val_l, cnt_l, ovr_l);
      end
      checks++;
      if ({out_m, val_m, cnt_m, ovr_m} !== '0) begin
         errors++;
         $display("FAIL reset_msb got out=%h val=%b cnt=%0d ovr=%b exp all 0", out_m, val_m, cnt_m, ovr_m);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] v;
      v = 8'hA5;
      ParDataRdy = 1'b1;
      q_l.push_back(8'hA5);
      q_m.push_back(8'hA5);
      for (int i = 0; i < W; i++) begin
         drive_bit(v[i], 1'b0);
         checks++;
         if (cnt_l !== CW'((i + 1) % W) || cnt_m !== CW'((i + 1) % W)) begin
            errors++;
            $display("FAIL basic_cnt bit %0d got %0d/%0d exp %0d", i, cnt_l, cnt_m, (i + 1) % W);
         end
      end
      checks++;
      if (val_l !== 1'b1 || out_l !== 8'hA5 || val_m !== 1'b1 || out_m !== 8'hA5) begin
         errors++;
         $display("FAIL basic_word got %b:%h %b:%h exp 1:a5 1:a5", val_l, out_l, val_m, out_m);
      end
      tick();
      checks++;
      if (val_l !== 1'b0 || val_m !== 1'b0) begin
         errors++;
         $display("FAIL basic_val_drop got %b/%b exp 0", val_l, val_m);
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] v;
      v = 8'hA5;
      ParDataRdy = 1'b1;
      q_l.push_back(8'hA5);
      q_m.push_back(8'hA5);
      for (int i = 0; i < W; i++) begin
         drive_bit(v[i], 1'b0);
         if (i == 2 || i == 5) begin
            for (int g = 0; g < 3; g++) begin
               tick();
               checks++;
               if (cnt_m !== CW'(i + 1)) begin
                  errors++;
                  $display("FAIL gap_cnt got %0d exp %0d", cnt_m, i + 1);
               end
            end
         end
      end
      checks++;
      if (val_m !== 1'b1 || out_m !== 8'hA5) begin
         errors++;
         $display("FAIL gap_word got %b:%h exp 1:a5", val_m, out_m);
      end
      tick();
   endtask

   task automatic test_overrun();
      ParDataRdy = 1'b0;
      send_word(8'h3C, 1'b1);
      send_word(8'hC3, 1'b0);
      checks++;
      if ({val_l, ovr_l, out_l} !== {1'b1, 1'b1, 8'h3C} || {val_m, ovr_m, out_m} !== {1'b1, 1'b1, 8'h3C}) begin
         errors++;
         $display("FAIL ovr_hold got %b%b:%h %b%b:%h exp 11:3c", val_l, ovr_l, out_l, val_m, ovr_m, out_m);
      end
      ParDataRdy = 1'b1;
      tick();
      ParDataRdy = 1'b0;
      checks++;
      if (val_l !== 1'b0 || ovr_l !== 1'b1) begin
         errors++;
         $display("FAIL ovr_accept got val=%b ovr=%b exp val=0 ovr=1", val_l, ovr_l);
      end
      OverrunClr = 1'b1;
      tick();
      OverrunClr = 1'b0;
      checks++;
      if (ovr_l !== 1'b0 || ovr_m !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear got %b/%b exp 0", ovr_l, ovr_m);
      end
   endtask

   task automatic test_overrun_priority();
      ParDataRdy = 1'b0;
      send_word(8'h5A, 1'b1);
      OverrunClr = 1'b1;
      send_word(8'h0F, 1'b0);
      OverrunClr = 1'b0;
      checks++;
      if (ovr_l !== 1'b1 || ovr_m !== 1'b1 || out_l !== 8'h5A) begin
         errors++;
         $display("FAIL ovr_set_wins got ovr=%b/%b out=%h exp 1/1 5a", ovr_l, ovr_m, out_l);
      end
      OverrunClr = 1'b1;
      ParDataRdy = 1'b1;
      tick();
      OverrunClr = 1'b0;
      ParDataRdy = 1'b0;
      checks++;
      if (ovr_l !== 1'b0 || val_l !== 1'b0) begin
         errors++;
         $display("FAIL ovr_drain got ovr=%b val=%b exp 0 0", ovr_l, val_l);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] v;
      ParDataRdy = 1'b0;
      send_word(8'h11, 1'b1);
      v = 8'h22;
      q_l.push_back(v);
      q_m.push_back(rev(v));
      for (int i = 0; i < W - 1; i++) drive_bit(v[i], 1'b0);
      ParDataRdy = 1'b1;
      drive_bit(v[W-1], 1'b0);
      ParDataRdy = 1'b0;
      checks++;
      if ({val_l, ovr_l, out_l} !== {1'b1, 1'b0, 8'h22} || out_m !== 8'h44) begin
         errors++;
         $display("FAIL b2b got val=%b ovr=%b out=%h msb=%h exp 1 0 22 44", val_l, ovr_l, out_l, out_m);
      end
      ParDataRdy = 1'b1;
      tick();
      ParDataRdy = 1'b0;
      checks++;
      if (val_l !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain got %b exp 0", val_l);
      end
   endtask

   task automatic test_resync();
      ParDataRdy = 1'b1;
      for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
      q_l.push_back(8'h01);
      q_m.push_back(8'h80);
      drive_bit(1'b1, 1'b1);
      checks++;
      if (cnt_l !== CW'(1) || cnt_m !== CW'(1) || val_l !== 1'b0) begin
         errors++;
         $display("FAIL resync_cnt got %0d/%0d val=%b exp 1/1 0", cnt_l, cnt_m, val_l);
      end
      for (int i = 0; i < 7; i++) drive_bit(1'b0, 1'b0);
      checks++;
      if (out_l !== 8'h01 || out_m !== 8'h80 || val_l !== 1'b1) begin
         errors++;
         $display("FAIL resync_word got %h/%h val=%b exp 01/80 1", out_l, out_m, val_l);
      end
      tick();
   endtask

   task automatic test_async_reset();
      ParDataRdy = 1'b0;
      send_word(8'h3C, 1'b1);
      send_word(8'hC3, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
      #2;
      Rst = 1'b1;
      #1;
      test_reset();
      q_l.delete();
      q_m.delete();
      tick();
      tick();
      checks++;
      if ({out_l, val_l, cnt_l, ovr_l} !== '0) begin
         errors++;
         $display("FAIL reset_hold got out=%h val=%b cnt=%0d ovr=%b exp all 0", out_l, val_l, cnt_l, ovr_l);
      end
      Rst = 1'b0;
      ParDataRdy = 1'b1;
      send_word(8'hFF, 1'b1);
      checks++;
      if (out_l !== 8'hFF || out_m !== 8'hFF || val_l !== 1'b1 || ovr_l !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got %h/%h val=%b ovr=%b exp ff/ff 1 0", out_l, out_m, val_l, ovr_l);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      Rst           = 1'b1;
      SerDataIn     = 1'b0;
      SerDataEn     = 1'b0;
      SerFrameStart = 1'b0;
      ParDataRdy    = 1'b0;
      OverrunClr    = 1'b0;
      tick();
      test_reset();
      tick();
      Rst = 1'b0;
      tick();
      test_basic();
      test_gaps();
      test_overrun();
      test_overrun_priority();
      test_back_to_back();
      test_resync();
      test_async_reset();
      checks++;
      if (q_l.size() != 0 || q_m.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d/%0d exp 0/0", q_l.size(), q_m.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
